id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- ID/EX pipeline register sitting directly downstream of controlUnit.
- Each cycle it latches the decoded control word (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) together with the ID-stage operands.
- It presents the latched values to the EX stage.
- It also performs load-use hazard detection: it inserts a one-cycle bubble and tells IF/ID to hold.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- REG_W, 5, register-specifier width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  branch-taken squash; next edge loads a bubble.
- ex_hold  input  1  downstream stall; register contents are frozen.
- id_valid  input  1  ID stage holds a real instruction.
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  input  1 each  from controlUnit.
- ALUOp  input  3  from controlUnit.
- id_pc4, id_rdata1, id_rdata2, id_imm  input  DATA_W each  ID operands (imm already sign-extended).
- id_rs, id_rt, id_rd  input  REG_W each  instruction register fields.
- ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  output  1 each  registered control.
- ex_ALUOp  output  3  registered ALUOp.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  output  DATA_W each  registered operands.
- ex_rs, ex_rt, ex_rd  output  REG_W each  registered register fields.
- ex_valid  output  1  EX holds a real instruction.
- load_use_stall  output  1  combinational; IF/ID and PC must hold this cycle.

Behaviour:
- Reset: while rst=1 (asynchronous), every registered output is 0, including ex_valid and ex_ALUOp=3'b000. load_use_stall is therefore 0.
- load_use_stall = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt). It is purely combinational, with no clock latency.
- Per rising edge, in priority order:
  - flush=1: load a bubble.
  - else ex_hold=1: all registers keep their value.
  - else load_use_stall=1: load a bubble.
  - else capture all inputs; ex_valid <= id_valid.
- Bubble definition: all seven 1-bit controls = 0, ALUOp = 0, ex_valid = 0, all data and register fields = 0.
- Capture when id_valid=0: control bits are still forced to 0 (no stray RegWrite/MemWrite), so an invalid instruction behaves exactly like a bubble.
- Latency: one cycle from ID inputs to ex_* outputs.
- Bubble length: a load-use bubble lasts exactly one cycle. After the bubble, ex_MemRead=0, so load_use_stall deasserts and the held instruction is captured on the following edge.
- flush and ex_hold both asserted: flush wins, because a squashed instruction must never remain in EX.
- ex_hold with load_use_stall=1: the register holds. load_use_stall stays asserted, which keeps IF/ID frozen as well; no bubble is inserted until ex_hold drops.
- rst mid-hold or mid-bubble: outputs clear immediately, with no dependence on clk. Normal capture resumes on the first edge after rst falls.
- No arithmetic is performed. All widths pass through unchanged.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-cycle while holding a captured R-type (RegWrite=1, ALUOp=3'b010).
  - Required response: all ex_* go to 0 before the next clk edge; ex_valid=0.
- Capture:
  - Stimulus: id_valid=1, RegWrite=1, RegDst=1, ALUOp=3'b010, id_rdata1=32'h0000_0005, id_rdata2=32'h0000_0003, id_rd=5'd8.
  - Required response: after one edge, ex_RegWrite=1, ex_RegDst=1, ex_ALUOp=3'b010, ex_rdata1=5, ex_rdata2=3, ex_rd=8, ex_valid=1.
- Load-use:
  - Stimulus: EX holds lw (MemRead=1, ex_rt=5'd9); ID presents an instruction with id_rs=5'd9.
  - Required response: load_use_stall=1 in the same cycle; the next edge gives ex_valid=0 with all controls 0; the edge after captures the held instruction; load_use_stall=0 throughout that capture cycle.
- $zero exemption:
  - Stimulus: lw with ex_rt=0 while id_rs=0.
  - Required response: load_use_stall=0; no bubble is inserted.
- Hold and flush:
  - Stimulus: assert ex_hold=1 for 3 edges with changing inputs.
  - Required response: outputs are unchanged for all 3 edges.
  - Stimulus: then assert flush=1 and ex_hold=1 together.
  - Required response: a bubble is loaded on the next edge.
- Invalid capture:
  - Stimulus: id_valid=0 with MemWrite=1 and RegWrite=1 on the inputs.
  - Required response: ex_MemWrite=0, ex_RegWrite=0, ex_valid=0.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_reg_if
// Bundle of the ID/EX pipeline register signals.
//   Upstream side (driven by ID stage / controlUnit / hazard sources):
//     flush, ex_hold, id_valid, the seven 1-bit controls, ALUOp,
//     id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd.
//   Downstream side (driven by the register):
//     ex_* registered copies, ex_valid, load_use_stall (combinational).
// modport master : the ID-side driver (drives inputs, observes outputs).
// modport slave  : the id_ex_reg block itself.
// Handshake: there is no valid/ready pair; id_valid/ex_valid qualify the
// payload, ex_hold freezes the register, load_use_stall asks IF/ID and the PC
// to hold in the same cycle it is asserted.
// -----------------------------------------------------------------------------
interface id_ex_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              ex_hold;
  logic              id_valid;
  logic              RegDst;
  logic              ALUSrc;
  logic              MemtoReg;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              Branch;
  logic [2:0]        ALUOp;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;

  logic              ex_RegDst;
  logic              ex_ALUSrc;
  logic              ex_MemtoReg;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_Branch;
  logic [2:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rdata1;
  logic [DATA_W-1:0] ex_rdata2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_valid;
  logic              load_use_stall;

  modport master (
    output flush, ex_hold, id_valid,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
    output id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
    input  ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
    input  ex_MemWrite, ex_Branch, ex_ALUOp,
    input  ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
    input  ex_valid, load_use_stall
  );

  modport slave (
    input  flush, ex_hold, id_valid,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
    input  id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
    output ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
    output ex_MemWrite, ex_Branch, ex_ALUOp,
    output ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
    output ex_valid, load_use_stall
  );
endinterface

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (clears every registered output)
//   bus  - id_ex_reg_if.slave: ID-side inputs, EX-side registered outputs and
//          the combinational load_use_stall request.
// Edge priority: flush > ex_hold > load_use_stall > capture.
// A bubble is the all-zero stage; capturing an instruction with id_valid=0
// also loads the all-zero stage so no stray RegWrite/MemWrite reaches EX.
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);

  typedef struct packed {
    logic              reg_dst;
    logic              alu_src;
    logic              memto_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              valid;
  } stage_t;

  stage_t r_stage;
  stage_t w_capture;
  logic   w_rt_match;
  logic   w_load_use_stall;

  // Invalid ID slots collapse to the bubble value.
  always_comb begin
    w_capture = '0;
    if (bus.id_valid) begin
      w_capture.reg_dst   = bus.RegDst;
      w_capture.alu_src   = bus.ALUSrc;
      w_capture.memto_reg = bus.MemtoReg;
      w_capture.reg_write = bus.RegWrite;
      w_capture.mem_read  = bus.MemRead;
      w_capture.mem_write = bus.MemWrite;
      w_capture.branch    = bus.Branch;
      w_capture.alu_op    = bus.ALUOp;
      w_capture.pc4       = bus.id_pc4;
      w_capture.rdata1    = bus.id_rdata1;
      w_capture.rdata2    = bus.id_rdata2;
      w_capture.imm       = bus.id_imm;
      w_capture.rs        = bus.id_rs;
      w_capture.rt        = bus.id_rt;
      w_capture.rd        = bus.id_rd;
      w_capture.valid     = 1'b1;
    end
  end

  // A load in EX whose destination ($rt) is read by the ID instruction.
  // $zero is never a real dependency.
  assign w_rt_match       = (r_stage.rt == bus.id_rs) || (r_stage.rt == bus.id_rt);
  assign w_load_use_stall = r_stage.valid & r_stage.mem_read & (r_stage.rt != '0) &
                            bus.id_valid & w_rt_match;

  // ex_hold outranks the stall bubble: while EX is frozen the load stays put,
  // the stall stays asserted and IF/ID stays frozen with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (bus.flush) begin
      r_stage <= '0;
    end else if (bus.ex_hold) begin
      r_stage <= r_stage;
    end else if (w_load_use_stall) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_capture;
    end
  end

  assign bus.ex_RegDst      = r_stage.reg_dst;
  assign bus.ex_ALUSrc      = r_stage.alu_src;
  assign bus.ex_MemtoReg    = r_stage.memto_reg;
  assign bus.ex_RegWrite    = r_stage.reg_write;
  assign bus.ex_MemRead     = r_stage.mem_read;
  assign bus.ex_MemWrite    = r_stage.mem_write;
  assign bus.ex_Branch      = r_stage.branch;
  assign bus.ex_ALUOp       = r_stage.alu_op;
  assign bus.ex_pc4         = r_stage.pc4;
  assign bus.ex_rdata1      = r_stage.rdata1;
  assign bus.ex_rdata2      = r_stage.rdata2;
  assign bus.ex_imm         = r_stage.imm;
  assign bus.ex_rs          = r_stage.rs;
  assign bus.ex_rt          = r_stage.rt;
  assign bus.ex_rd          = r_stage.rd;
  assign bus.ex_valid       = r_stage.valid;
  assign bus.load_use_stall = w_load_use_stall;

endmodule
